// File: rtl/mux_8to1_pkg.sv
// Shared constants for the 8:1 single-bit multiplexer.
package mux_8to1_pkg;

   localparam int unsigned MUX_SEL_W = 3;
   localparam int unsigned MUX_N     = 2 ** MUX_SEL_W;

endpackage : mux_8to1_pkg

// File: rtl/mux_8to1_mux2to1.sv
// Single-bit 2:1 mux leaf; y follows b when s is high, a otherwise.
module mux2to1 (
   input  logic a,
   input  logic b,
   input  logic s,
   output logic y
);

   assign y = s ? b : a;

endmodule : mux2to1

// File: rtl/mux_8to1.sv
// 8:1 single-bit mux built as a binary tree of 2:1 muxes, with a registered
// copy of the selected bit and a one-cycle valid flag.
module mux_8to1
   import mux_8to1_pkg::*;
#(
   parameter int unsigned SEL_W = MUX_SEL_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2**SEL_W-1:0]   in,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  in_valid,
   output logic                  out,
   output logic                  out_q,
   output logic                  out_valid
);

   localparam int unsigned N = 2 ** SEL_W;

   // Heap-ordered tree: node k has children 2k+1 (a) and 2k+2 (b); leaves
   // occupy N-1..2N-2 so in[0] is leftmost and the root is node 0.
   logic [2*N-2:0] node;

   assign node[2*N-2:N-1] = in;

   // Deepest level steers with sel[0], the root with sel[SEL_W-1].
   for (genvar d = 0; d < SEL_W; d++) begin : g_lvl
      for (genvar m = 0; m < 2 ** d; m++) begin : g_node
         localparam int unsigned K = 2 ** d - 1 + m;
         mux2to1 u_mux (
            .a (node[2*K+1]),
            .b (node[2*K+2]),
            .s (sel[SEL_W-1-d]),
            .y (node[K])
         );
      end
   end

   assign out = node[0];

   logic out_d;
   logic valid_d;
   logic valid_q;

   // Capture only when qualified; otherwise hold the last captured bit.
   always_comb begin
      out_d   = out_q;
      valid_d = in_valid;
      if (in_valid) begin
         out_d = out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;

endmodule : mux_8to1

// File: tb/tb_mux_8to1.sv
// Randomized and directed scoreboard bench for mux_8to1.
module tb_mux_8to1;

   logic       clk;
   logic       rst_n;
   logic [7:0] din;
   logic [2:0] sel;
   logic       in_valid;
   logic       out;
   logic       out_q;
   logic       out_valid;

   int n_vec  = 0;
   int n_miss = 0;

   logic exp_q[$];
   logic exp_vld  = 1'b0;
   logic hold_bit = 1'b0;

   mux_8to1 #(.SEL_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (din),
      .sel       (sel),
      .in_valid  (in_valid),
      .out       (out),
      .out_q     (out_q),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic ref_bit(input logic [7:0] v, input logic [2:0] s);
      logic [7:0] shifted;
      shifted = v >> s;
      return shifted[0];
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b (in=%b sel=%0d t=%0t)", name, act, exp, din, sel, $time);
      end
   endtask

   // Reference: every qualified edge out of reset produces one expected bit.
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         exp_vld = in_valid;
         if (in_valid) exp_q.push_back(ref_bit(din, sel));
      end
   end

   always @(negedge rst_n) begin
      exp_q.delete();
      exp_vld  = 1'b0;
      hold_bit = 1'b0;
   end

   // Monitor: sample away from the active edge and retire expected bits.
   always @(negedge clk) begin
      chk("out_comb", out, ref_bit(din, sel));
      chk("out_valid", out_valid, exp_vld);
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_empty: got out_valid=1 expected no pending capture");
         end else begin
            hold_bit = exp_q.pop_front();
            chk("out_q_new", out_q, hold_bit);
         end
      end else begin
         chk("out_q_hold", out_q, hold_bit);
      end
   end

   task automatic drive(input logic [7:0] v, input logic [2:0] s, input logic vld);
      din      = v;
      sel      = s;
      in_valid = vld;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] v;
      rst_n = 1'b0;
      drive(8'hFF, 3'b111, 1'b1);
      #1;
      chk("rst_out_q", out_q, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out", out, 1'b1);
      step();
      step();
      chk("rst_hold_out_q", out_q, 1'b0);
      chk("rst_hold_out_valid", out_valid, 1'b0);

      drive(8'h00, 3'b000, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("zero_sel0", out, 1'b0);

      for (int k = 0; k < 8; k++) begin
         v = 8'(1 << k);
         drive(v, 3'(k), 1'b0);
         #1;
         chk("walk_one", out, 1'b1);
      end

      drive(8'b11110000, 3'b010, 1'b0); #1; chk("ignore_hi", out, 1'b0);
      drive(8'b10101010, 3'b100, 1'b0); #1; chk("ignore_alt4", out, 1'b0);
      drive(8'b10101010, 3'b001, 1'b0); #1; chk("alt_sel1", out, 1'b1);

      for (int i = 0; i < 256; i++) begin
         for (int s = 0; s < 8; s++) begin
            v = 8'(i);
            drive(v, 3'(s), 1'b0);
            #1;
            chk("exhaustive", out, v[s]);
         end
      end

      step();
      drive(8'b00000100, 3'b010, 1'b1);
      step();
      chk("cap_out_q", out_q, 1'b1);
      chk("cap_out_valid", out_valid, 1'b1);
      drive(8'h00, 3'b010, 1'b0);
      step();
      chk("hold_out_q", out_q, 1'b1);
      chk("hold_out_valid", out_valid, 1'b0);

      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_q", out_q, 1'b0);
      chk("midrst_out_valid", out_valid, 1'b0);
      step();
      rst_n = 1'b1;
      drive(8'b10000000, 3'b111, 1'b1);
      step();
      chk("post_rst_out_q", out_q, 1'b1);
      chk("post_rst_out_valid", out_valid, 1'b1);

      for (int c = 0; c < 400; c++) begin
         drive(8'($urandom), 3'($urandom_range(0, 7)), logic'($urandom_range(0, 3) != 0));
         step();
      end

      drive(8'h00, 3'b000, 1'b0);
      step();
      step();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL sb_drain: got %0d pending captures expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_mux_8to1
